// File: rtl/serial_pattern_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : serial_pattern_transmitter
// Description : Shifts a latched 1-8 bit pattern out MSB-first, repeated with
//               idle gaps, and shows transfer status on a 7-segment output.
// Revision    : 1.0 - initial release
// ============================================================================
module serial_pattern_transmitter #(
  parameter int unsigned CLKS_PER_BIT = 1,
  parameter bit          IDLE_LEVEL   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       start,
  input  logic       abort,
  input  logic [7:0] pattern,
  input  logic [2:0] len,
  input  logic [3:0] reps,
  output logic       tx_bit,
  output logic       tx_valid,
  output logic       busy,
  output logic       done,
  output logic [7:0] seg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_SEND = 2'd1;
  localparam logic [1:0] S_GAP  = 2'd2;
  localparam logic [1:0] S_DONE = 2'd3;

  localparam logic [7:0] C_HOLD_LAST = 8'(CLKS_PER_BIT - 1);
  localparam logic [7:0] C_SEG_IDLE  = 8'b0000_0010;
  localparam logic [7:0] C_SEG_BUSY  = 8'b1000_0010;
  localparam logic [7:0] C_SEG_DONE  = 8'b1111_1111;

  logic [1:0] state_q, state_d;
  logic [7:0] pat_q, pat_d;
  logic [2:0] last_idx_q, last_idx_d;
  logic [2:0] idx_q, idx_d;
  logic [3:0] pass_q, pass_d;
  logic [7:0] hold_q, hold_d;
  logic       sticky_q, sticky_d;
  logic       tx_bit_q, tx_bit_d;
  logic       tx_valid_q, tx_valid_d;
  logic       busy_q, busy_d;
  logic       done_q, done_d;
  logic [7:0] seg_q, seg_d;
  logic       hold_last;

  assign hold_last = (hold_q == C_HOLD_LAST);

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state_q    <= S_IDLE;
      pat_q      <= 8'd0;
      last_idx_q <= 3'd0;
      idx_q      <= 3'd0;
      pass_q     <= 4'd0;
      hold_q     <= 8'd0;
      sticky_q   <= 1'b0;
      tx_bit_q   <= IDLE_LEVEL;
      tx_valid_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      seg_q      <= C_SEG_IDLE;
    end else begin
      state_q    <= state_d;
      pat_q      <= pat_d;
      last_idx_q <= last_idx_d;
      idx_q      <= idx_d;
      pass_q     <= pass_d;
      hold_q     <= hold_d;
      sticky_q   <= sticky_d;
      tx_bit_q   <= tx_bit_d;
      tx_valid_q <= tx_valid_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      seg_q      <= seg_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    pat_d      = pat_q;
    last_idx_d = last_idx_q;
    idx_d      = idx_q;
    pass_d     = pass_q;
    hold_d     = hold_q;
    sticky_d   = sticky_q;
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (start) begin
            // len wraps 0 -> 7, so len-1 is the first index for every L in 1..8
            state_d    = S_SEND;
            pat_d      = pattern;
            last_idx_d = len - 3'd1;
            idx_d      = len - 3'd1;
            pass_d     = reps;
            hold_d     = 8'd0;
            sticky_d   = 1'b0;
          end
        end
        S_SEND: begin
          if (hold_last) begin
            hold_d = 8'd0;
            if (idx_q == 3'd0) begin
              if (pass_q != 4'd0) begin
                pass_d  = pass_q - 4'd1;
                state_d = S_GAP;
              end else begin
                state_d = S_DONE;
              end
            end else begin
              idx_d = idx_q - 3'd1;
            end
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
        S_GAP: begin
          if (hold_last) begin
            hold_d  = 8'd0;
            idx_d   = last_idx_q;
            state_d = S_SEND;
          end else begin
            hold_d = hold_q + 8'd1;
          end
        end
        default: begin
          sticky_d = 1'b1;
          state_d  = S_IDLE;
        end
      endcase
    end
  end

  // Outputs are derived from next-state values so they register in step with the FSM
  always_comb begin
    tx_bit_d   = IDLE_LEVEL;
    tx_valid_d = 1'b0;
    busy_d     = 1'b0;
    done_d     = 1'b0;
    seg_d      = sticky_d ? C_SEG_DONE : C_SEG_IDLE;
    case (state_d)
      S_SEND: begin
        tx_bit_d   = pat_d[idx_d];
        tx_valid_d = 1'b1;
        busy_d     = 1'b1;
        seg_d      = C_SEG_BUSY;
      end
      S_GAP: begin
        busy_d = 1'b1;
        seg_d  = C_SEG_BUSY;
      end
      S_DONE: begin
        done_d = 1'b1;
        seg_d  = C_SEG_DONE;
      end
      default: ;
    endcase
  end

  assign tx_bit   = tx_bit_q;
  assign tx_valid = tx_valid_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign seg      = seg_q;

endmodule
`default_nettype wire

// File: tb/tb_serial_pattern_transmitter.sv
`default_nettype none
// ============================================================================
// Module      : tb_serial_pattern_transmitter
// Description : Three transmitters (hold 1/2/3 clocks) driven in parallel and
//               compared cycle by cycle with a queue-based reference.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_serial_pattern_transmitter;

  localparam logic [7:0] C_SEG_IDLE = 8'b0000_0010;
  localparam logic [7:0] C_SEG_BUSY = 8'b1000_0010;
  localparam logic [7:0] C_SEG_DONE = 8'b1111_1111;

  typedef struct {
    logic [7:0] pat;
    logic [2:0] ln;
    logic [3:0] rp;
    int         exp_valid;
    int         exp_busy;
  } vec_t;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       start;
  logic       abort;
  logic [7:0] pattern;
  logic [2:0] len;
  logic [3:0] reps;
  logic       tx_bit_w   [3];
  logic       tx_valid_w [3];
  logic       busy_w     [3];
  logic       done_w     [3];
  logic [7:0] seg_w      [3];

  int n_checks = 0;
  int n_fail   = 0;
  logic [11:0] exp_q [3][$];
  vec_t tbl [6];

  always #5 clk = ~clk;

  // Instance d holds each bit d+1 clocks; the last one idles high
  for (genvar g = 0; g < 3; g++) begin : g_dut
    serial_pattern_transmitter #(
      .CLKS_PER_BIT (g + 1),
      .IDLE_LEVEL   ((g == 2) ? 1'b1 : 1'b0)
    ) u_dut (
      .clk      (clk),
      .rst_n    (rst_n),
      .start    (start),
      .abort    (abort),
      .pattern  (pattern),
      .len      (len),
      .reps     (reps),
      .tx_bit   (tx_bit_w[g]),
      .tx_valid (tx_valid_w[g]),
      .busy     (busy_w[g]),
      .done     (done_w[g]),
      .seg      (seg_w[g])
    );
  end

  function automatic logic idle_of(input int d);
    return (d == 2);
  endfunction

  function automatic logic [11:0] outs(input int d);
    return {tx_bit_w[d], tx_valid_w[d], busy_w[d], done_w[d], seg_w[d]};
  endfunction

  task automatic check(input string nm, input int d, input int k,
                       input logic [11:0] act, input logic [11:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc%0d: got {bit,vld,busy,done,seg}=%h expected %h",
               nm, d, k, act, exp);
    end
  endtask

  task automatic check_int(input string nm, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  task automatic check_reset(input string nm);
    for (int d = 0; d < 3; d++)
      check(nm, d, 0, outs(d), {idle_of(d), 3'b000, C_SEG_IDLE});
  endtask

  // Reference: each pass is L bits (MSB of the L-bit field first) held c clocks,
  // passes separated by c idle clocks, then one done cycle.
  task automatic build_model(input logic [7:0] pat, input logic [2:0] ln, input logic [3:0] rp);
    int L;
    int P;
    L = (ln == 3'd0) ? 8 : int'(ln);
    P = int'(rp) + 1;
    for (int d = 0; d < 3; d++) begin
      exp_q[d].delete();
      for (int p = 0; p < P; p++) begin
        for (int j = 0; j < L; j++)
          repeat (d + 1) exp_q[d].push_back({pat[L-1-j], 3'b110, C_SEG_BUSY});
        if (p != P - 1)
          repeat (d + 1) exp_q[d].push_back({idle_of(d), 3'b010, C_SEG_BUSY});
      end
      exp_q[d].push_back({idle_of(d), 3'b001, C_SEG_DONE});
    end
  endtask

  // Called at a negedge with all instances idle; scrambles inputs after the latch.
  task automatic run_txn(input string nm, input logic [7:0] pat, input logic [2:0] ln,
                         input logic [3:0] rp, input int mid_start,
                         output int vcnt, output int bcnt);
    int maxlen;
    logic [11:0] exp;
    build_model(pat, ln, rp);
    maxlen = exp_q[2].size() + 2;
    vcnt = 0;
    bcnt = 0;
    pattern = pat;
    len     = ln;
    reps    = rp;
    start   = 1'b1;
    @(posedge clk);
    for (int k = 0; k < maxlen; k++) begin
      @(negedge clk);
      if (k == 0) begin
        start   = 1'b0;
        pattern = 8'($urandom);
        len     = 3'($urandom);
        reps    = 4'($urandom);
      end
      if (k == mid_start)     start = 1'b1;
      if (k == mid_start + 1) start = 1'b0;
      for (int d = 0; d < 3; d++) begin
        exp = (k < exp_q[d].size()) ? exp_q[d][k] : {idle_of(d), 3'b000, C_SEG_DONE};
        check(nm, d, k + 1, outs(d), exp);
      end
      if (tx_valid_w[0]) vcnt++;
      if (busy_w[0])     bcnt++;
    end
  endtask

  initial begin
    #3_000_000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int v;
    int b;
    tbl[0] = '{8'b0000_0100, 3'd3, 4'd0,  3,  3};
    tbl[1] = '{8'hA5,        3'd0, 4'd0,  8,  8};
    tbl[2] = '{8'b0000_0010, 3'd2, 4'd2,  6,  8};
    tbl[3] = '{8'h01,        3'd1, 4'd0,  1,  1};
    tbl[4] = '{8'hFF,        3'd7, 4'd1, 14, 15};
    tbl[5] = '{8'h3C,        3'd5, 4'd15, 80, 95};

    rst_n = 1'b1; start = 1'b0; abort = 1'b0;
    pattern = 8'd0; len = 3'd0; reps = 4'd0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst_n = 1'b0;
    @(negedge clk);

    for (int i = 0; i < 6; i++) begin
      run_txn("table", tbl[i].pat, tbl[i].ln, tbl[i].rp, -1, v, b);
      check_int("tbl_valid_cycles", v, tbl[i].exp_valid);
      check_int("tbl_busy_cycles", b, tbl[i].exp_busy);
    end

    for (int i = 0; i < 16; i++)
      run_txn("random", 8'($urandom), 3'($urandom_range(0, 7)), 4'($urandom_range(0, 3)), -1, v, b);

    // start pulsed mid-SEND must leave the transfer untouched
    run_txn("mid_start", 8'b1_0110, 3'd5, 4'd0, 1, v, b);
    check_int("mid_start_valid", v, 5);

    // abort during the second bit
    pattern = 8'b1_0110; len = 3'd5; reps = 4'd0; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk); abort = 1'b1;
    @(negedge clk); abort = 1'b0;
    for (int d = 0; d < 3; d++) check("abort", d, 3, outs(d), {idle_of(d), 3'b000, C_SEG_IDLE});
    for (int k = 0; k < 12; k++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) check("abort_no_done", d, k, {11'd0, done_w[d]}, 12'd0);
    end

    // abort wins over start in IDLE
    start = 1'b1; abort = 1'b1;
    @(negedge clk); start = 1'b0; abort = 1'b0;
    for (int d = 0; d < 3; d++) check("abort_start", d, 0, outs(d), {idle_of(d), 3'b000, C_SEG_IDLE});

    // asynchronous reset while the 1-clock instance sits in GAP
    pattern = 8'b10; len = 3'd2; reps = 4'd2; start = 1'b1;
    @(posedge clk);
    @(negedge clk); start = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("in_gap", 0, 3, {10'd0, tx_valid_w[0], busy_w[0]}, 12'b01);
    #1 rst_n = 1'b1;
    #1 check_reset("async_reset");
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk);
    run_txn("post_reset", 8'b10, 3'd2, 4'd2, -1, v, b);
    check_int("post_reset_valid", v, 6);

    // start held high: SEND x c, DONE, IDLE, repeat
    pattern = 8'h01; len = 3'd1; reps = 4'd0; start = 1'b1;
    @(posedge clk);
    for (int k = 1; k <= 12; k++) begin
      @(negedge clk);
      for (int d = 0; d < 3; d++) begin
        int ph;
        ph = (k - 1) % (d + 3);
        check("b2b", d, k, {10'd0, tx_valid_w[d], done_w[d]},
              {10'd0, (ph < d + 1), (ph == d + 1)});
      end
    end
    start = 1'b0;
    repeat (10) @(negedge clk);
    for (int d = 0; d < 3; d++) check("b2b_settle", d, 0, outs(d), {idle_of(d), 3'b000, C_SEG_DONE});

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/serial_pattern_transmitter.md
# serial_pattern_transmitter

Serial bit-pattern transmitter that drives a single-bit stream into the team's sequence-detector input (`ui_in[0]` style).
- Latches a programmable pattern of 1–8 bits and shifts it out MSB-first, holding each bit for a programmable number of clocks.
- Repeats the pattern a programmable number of times, with an idle gap between passes.
- Reports status on a 7-segment output.

This block is the stimulus/transmit end of the detector link. The "100" test pattern comes from here.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 1: clocks each bit is held. Legal range 1–255.
- `IDLE_LEVEL`, default 0: `tx_bit` value whenever no bit is being sent.

Ports:
- `clk`  input  1  clock. All state updates on the rising edge.
- `rst_n`  input  1  reset: asynchronous, active-high. Despite the `_n` name, 1 = reset.
- `start`  input  1  transmit request. Sampled only in IDLE.
- `abort`  input  1  synchronous cancel. Higher priority than `start`.
- `pattern`  input  8  bits to send. `pattern[L-1]` is sent first, `pattern[0]` last.
- `len`  input  3  pattern length L. Values 1–7 give L = `len`; 0 gives L = 8.
- `reps`  input  4  extra passes. Total passes P = `reps`+1 (1–16).
- `tx_bit`  output  1  serial data.
- `tx_valid`  output  1  high while `tx_bit` carries a pattern bit.
- `busy`  output  1  high in SEND and GAP.
- `done`  output  1  one-cycle pulse when the final pass completes.
- `seg`  output  8  7-segment status display.

## Operation

State machine: IDLE, SEND, GAP, DONE. Reset state is IDLE.

Reset values:
- Outputs: `tx_bit`=`IDLE_LEVEL`, `tx_valid`=0, `busy`=0, `done`=0, `seg`=8'b00000010.
- Internal: sticky done flag=0, shadow registers=0.

IDLE:
- With `start`=1 and `abort`=0, the block latches `pattern`, L and P into shadow registers, loads the bit index with L-1, clears the hold counter and the sticky done flag, and moves to SEND.
- Input changes after this latch have no effect on the transfer in progress.

SEND:
- `tx_bit` = shadow `pattern[idx]`, `tx_valid`=1.
- The hold counter counts 0 to `CLKS_PER_BIT`-1. At terminal count the bit index decrements.
- After idx 0 reaches terminal count:
  - If passes remain: decrement the pass count and go to GAP.
  - Otherwise: go to DONE.

GAP:
- `tx_bit`=`IDLE_LEVEL`, `tx_valid`=0, `busy`=1.
- Lasts `CLKS_PER_BIT` cycles, then reloads idx=L-1 and returns to SEND.

DONE:
- Lasts one cycle: `done`=1, `busy`=0, `tx_valid`=0.
- Sets the sticky done flag, then goes to IDLE.

Abort:
- `abort`=1 in any state moves to IDLE on the next edge.
- No `done` pulse, sticky flag unchanged, `tx_valid`=0 on the next cycle.
- `abort` together with `start` in IDLE: remain in IDLE.

Start outside IDLE:
- `start` is ignored in SEND, GAP and DONE. Requests are not queued.
- Back-to-back operation: `start` held high through DONE begins a new transfer on the first IDLE cycle.

`seg` (registered from the next state):
- IDLE with sticky flag 0: 8'b00000010 ('-').
- SEND or GAP: 8'b10000010 ('-' with dot).
- DONE, and IDLE with sticky flag 1: 8'b11111111 ('8.').

Widths:
- idx: 3 bits.
- Pass counter: 4 bits, counts down from P-1.
- Hold counter: 8 bits, reset to 0 on every bit and on every gap.

## Timing

- Start latency: `start` sampled at edge E0 puts the first bit on `tx_bit` with `tx_valid`=1 in the cycle after E0. All outputs are registered.
- Transfer length, from the cycle after E0 through the last GAP/SEND cycle: P·L·`CLKS_PER_BIT` + (P-1)·`CLKS_PER_BIT` cycles. `done` is high in the following cycle.
- Earliest next start: `start` is accepted at the edge ending the DONE cycle plus one, i.e. the first IDLE edge.
- Asynchronous reset: `rst_n` asserted mid-transfer forces all outputs to their reset values immediately, without waiting for a clock edge.

## Test plan

- `pattern`=8'b00000100, `len`=3, `reps`=0, `CLKS_PER_BIT`=1, `start` pulse at E0 → `tx_bit` 1,0,0 with `tx_valid`=1 in cycles 1–3, `done`=1 in cycle 4, `seg`=8'hFF from cycle 4. A connected sequence detector then flags detection.
- `pattern`=8'hA5, `len`=0 (L=8), `CLKS_PER_BIT`=3 → 1,0,1,0,0,1,0,1, each bit held exactly 3 cycles, 24 valid cycles, then `done`.
- `len`=2, `pattern`=8'b10, `reps`=2, `CLKS_PER_BIT`=2 → three passes of 1,1,0,0 separated by two 2-cycle gaps with `tx_valid`=0 and `tx_bit`=`IDLE_LEVEL`; `busy` held high for 16 cycles; single `done` pulse.
- `abort` asserted in the 2nd bit of a 5-bit send → IDLE next cycle, `tx_valid`=0, no `done`, `seg`=8'b00000010. Repeat with `start` pulsed mid-SEND → ignored; bit sequence and total length unchanged.
- `rst_n`=1 asserted mid-GAP between clock edges → outputs immediately at reset values. After release, `start` → normal transfer from the first bit.
- `start` held high continuously with `len`=1, `pattern`=1 → repeating cycle of SEND, DONE, IDLE: `tx_valid` pulses every 3 cycles, and `done` follows each pulse by one cycle.
